quad_counter_bank: RTL and testbench

QUAD_COUNTER_BANK -- requirements
Module: quad_counter_bank

---
 rtl/quad_counter_bank.sv | 137 +++++++++++++
 tb/tb_quad_counter_bank.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/quad_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | quad_counter_bank: bank of filtered quadrature decoders with snapshot      |
// | readout and sticky double-step error flags, selected per channel.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module quad_counter_bank #(
    parameter int  CHANNELS = 4,
    parameter int  WIDTH    = 8,
    parameter int  FILTER   = 3,
    parameter int  SAT      = 0,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] a,
    input  logic [CHANNELS-1:0] b,
    input  logic [SEL_W-1:0]    sel,
    input  logic                snap,
    input  logic                clr,
    output logic [WIDTH-1:0]    dout,
    output logic                err
);
    localparam int               c_nb        = 2 * CHANNELS;
    localparam int               c_fcw       = 4;
    localparam int               c_nsel      = 1 << SEL_W;
    localparam logic [c_fcw-1:0] c_filt_last = c_fcw'(FILTER - 1);
    localparam logic [WIDTH-1:0] c_max       = '1;

    // Bits [2*CHANNELS-1:CHANNELS] carry phase A, bits [CHANNELS-1:0] phase B.
    logic [c_nb-1:0]     r_sync1;
    logic [c_nb-1:0]     r_sync2;
    logic [c_nb-1:0]     r_filt;
    logic [c_nb-1:0]     r_prev;
    logic [c_fcw-1:0]    r_fcnt   [c_nb];
    logic [WIDTH-1:0]    r_count  [CHANNELS];
    logic [WIDTH-1:0]    r_snap   [CHANNELS];
    logic [CHANNELS-1:0] r_err;

    logic [1:0]          w_delta    [CHANNELS];
    logic [CHANNELS-1:0] w_clr_hit;
    logic [WIDTH-1:0]    w_snap_pad [c_nsel];
    logic [c_nsel-1:0]   w_err_pad;

    // Gray {A,B} to position 0..3 so a step is the mod-4 difference of positions.
    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            r_prev  <= '0;
            for (int j = 0; j < c_nb; j++) begin
                r_fcnt[j] <= '0;
            end
        end else begin
            r_sync1 <= {a, b};
            r_sync2 <= r_sync1;
            r_prev  <= r_filt;
            for (int j = 0; j < c_nb; j++) begin
                if (r_sync2[j] == r_filt[j]) begin
                    r_fcnt[j] <= '0;
                end else if (r_fcnt[j] == c_filt_last) begin
                    r_filt[j] <= r_sync2[j];
                    r_fcnt[j] <= '0;
                end else begin
                    r_fcnt[j] <= r_fcnt[j] + c_fcw'(1);
                end
            end
        end
    end

    always_comb begin
        w_clr_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_delta[i]   = gray_pos({r_filt[CHANNELS+i], r_filt[i]})
                         - gray_pos({r_prev[CHANNELS+i], r_prev[i]});
            w_clr_hit[i] = clr && (sel == SEL_W'(i));
        end
    end

    // delta 1 = forward, 3 = reverse, 2 = both phases moved at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_count[i] <= '0;
                r_snap[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (snap) begin
                    r_snap[i] <= r_count[i];
                end
                if (w_clr_hit[i]) begin
                    r_count[i] <= '0;
                    r_err[i]   <= 1'b0;
                end else if (w_delta[i] == 2'd1) begin
                    if (!(SAT != 0 && r_count[i] == c_max)) begin
                        r_count[i] <= r_count[i] + WIDTH'(1);
                    end
                end else if (w_delta[i] == 2'd3) begin
                    if (!(SAT != 0 && r_count[i] == '0)) begin
                        r_count[i] <= r_count[i] - WIDTH'(1);
                    end
                end else if (w_delta[i] == 2'd2) begin
                    r_err[i] <= 1'b1;
                end
            end
        end
    end

    // Select codes beyond the last channel read back as zero.
    for (genvar k = 0; k < c_nsel; k++) begin : g_pad
        if (k < CHANNELS) begin : g_live
            assign w_snap_pad[k] = r_snap[k];
            assign w_err_pad[k]  = r_err[k];
        end else begin : g_void
            assign w_snap_pad[k] = '0;
            assign w_err_pad[k]  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
            err  <= 1'b0;
        end else begin
            dout <= w_snap_pad[sel];
            err  <= w_err_pad[sel];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_quad_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_quad_counter_bank: directed scoreboard bench for quad_counter_bank.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_quad_counter_bank;
    localparam int CH = 4;
    localparam int W  = 8;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [CH-1:0] a    = '0;
    logic [CH-1:0] b    = '0;
    logic [1:0]   sel   = '0;
    logic         snap  = 1'b0;
    logic         clr   = 1'b0;
    logic [W-1:0] dout;
    logic         err;
    logic [W-1:0] dout_s;
    logic         err_s;

    typedef struct {
        logic [W-1:0] d;
        logic         e;
    } exp_t;
    exp_t q[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    quad_counter_bank #(.CHANNELS(4), .WIDTH(8), .FILTER(3), .SAT(0)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .sel(sel),
        .snap(snap), .clr(clr), .dout(dout), .err(err)
    );

    // Three-channel clamping variant: covers SAT=1 and the out-of-range select.
    quad_counter_bank #(.CHANNELS(3), .WIDTH(8), .FILTER(3), .SAT(1)) dut_sat (
        .clk(clk), .reset(reset), .a(a[2:0]), .b(b[2:0]), .sel(sel),
        .snap(snap), .clr(clr), .dout(dout_s), .err(err_s)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = q.pop_front();
            check({tag, ".dout"}, 16'(dout), 16'(e.d));
            check({tag, ".err"}, 16'(err), 16'(e.e));
        end
    endtask

    task automatic pulse_snap(input logic [W-1:0] d, input logic e);
        snap = 1'b1;
        q.push_back('{d: d, e: e});
        tick(1);
        snap = 1'b0;
    endtask

    task automatic snap_check(input string tag, input logic [W-1:0] d, input logic e);
        pulse_snap(d, e);
        tick(1);
        pop_check(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a = '0;
        b = '0;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick(3);
        check("reset.dout", 16'(dout), 16'h0);
        check("reset.err", 16'(err), 16'h0);
        reset = 1'b0;

        // Forward cycle on channel 0; first step lands 6 edges after the pin edge
        sel  = 2'd0;
        b[0] = 1'b1;
        tick(5);
        pulse_snap(8'd0, 1'b0);
        pulse_snap(8'd1, 1'b0);
        pop_check("lat_pre");
        tick(1);
        pop_check("lat_post");
        a[0] = 1'b1; tick(8);
        b[0] = 1'b0; tick(8);
        a[0] = 1'b0; tick(8);
        snap_check("fwd4", 8'd4, 1'b0);

        // Reverse step from zero: wrap vs clamp, then back up
        do_reset();
        a[0] = 1'b1;
        tick(8);
        snap_check("wrap_dn", 8'd255, 1'b0);
        check("sat_dn.dout", 16'(dout_s), 16'd0);
        a[0] = 1'b0;
        tick(8);
        snap_check("wrap_up", 8'd0, 1'b0);
        check("sat_up.dout", 16'(dout_s), 16'd1);

        // Glitch filtering on a[1]
        do_reset();
        sel  = 2'd1;
        a[1] = 1'b1; tick(2);
        a[1] = 1'b0; tick(10);
        snap_check("glitch2", 8'd0, 1'b0);
        a[1] = 1'b1; tick(3);
        a[1] = 1'b0; tick(3);
        snap_check("glitch3", 8'd255, 1'b0);
        tick(6);
        snap_check("glitch3_back", 8'd0, 1'b0);

        // Double-bit transition on channel 2, channel 3 counts once
        do_reset();
        sel  = 2'd2;
        b[3] = 1'b1;
        a[2] = 1'b1;
        b[2] = 1'b1;
        tick(10);
        snap_check("dbl_err", 8'd0, 1'b1);
        check("sat_dbl.err", 16'(err_s), 16'd1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        snap_check("dbl_clr", 8'd0, 1'b0);
        sel = 2'd3;
        snap_check("ch3_keep", 8'd1, 1'b0);
        check("sat_oor.dout", 16'(dout_s), 16'd0);
        check("sat_oor.err", 16'(err_s), 16'd0);

        // snap + clr + step on channel 0 in one cycle
        do_reset();
        sel  = 2'd0;
        b[0] = 1'b1;
        tick(8);
        a[0] = 1'b1;
        tick(5);
        snap = 1'b1;
        clr  = 1'b1;
        q.push_back('{d: 8'd1, e: 1'b0});
        tick(1);
        snap = 1'b0;
        clr  = 1'b0;
        tick(1);
        pop_check("coll_snap");
        snap_check("coll_live", 8'd0, 1'b0);

        // Reset while a filter counter sits at 2 with a nonzero count
        b[0] = 1'b0;
        tick(8);
        snap_check("pre_rst", 8'd1, 1'b0);
        a[0] = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(1);
        check("midrst.dout", 16'(dout), 16'h0);
        check("midrst.err", 16'(err), 16'h0);
        reset = 1'b0;
        tick(10);
        snap_check("post_rst", 8'd0, 1'b0);
        b[0] = 1'b1;
        tick(8);
        snap_check("post_rst_step", 8'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
